seg_scan_driver: RTL and testbench

Four-digit multiplexed seven-segment driver for the reaction tester display. It sits directly downstream of the binary-to-BCD converter and takes its 16-bit packed BCD result (thousands:hundreds:tens:units). It latches the value together with a display-mode code and scans the digits with a programmable dwell time and an anti-ghosting blank window. In number mode it suppresses leading zeros; it can also show the fixed patterns FAIL and ----.

---
 rtl/seg_scan_driver.sv | 155 +++++++++++++++
 tb/tb_seg_scan_driver.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment scanner with leading-zero suppression,
// fixed FAIL / dash patterns and a programmable anti-ghosting blank window.
module seg_scan_driver #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_data_bcd,
  input  logic [1:0]  i_disp_state,
  input  logic        i_load,
  output logic [7:0]  o_seg,
  output logic [3:0]  o_an
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_L  = CW'(BLANK_CYC);

  // Glyphs are {dp,g,f,e,d,c,b,a}, active-low, dp always off.
  localparam logic [7:0] G_DASH  = 8'hBF;
  localparam logic [7:0] G_BLANK = 8'hFF;
  localparam logic [7:0] G_E     = 8'h86;
  localparam logic [7:0] G_F     = 8'h8E;
  localparam logic [7:0] G_A     = 8'h88;
  localparam logic [7:0] G_I     = 8'hCF;
  localparam logic [7:0] G_L     = 8'hC7;

  typedef enum logic [1:0] {
    MODE_NUM   = 2'b00,
    MODE_FAIL  = 2'b01,
    MODE_DASH  = 2'b10,
    MODE_BLANK = 2'b11
  } mode_e;

  logic [15:0]   data_q;
  mode_e         mode_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;

  logic [3:0]    nib;
  logic          lz_blank;
  logic          blank_win;

  function automatic logic [7:0] digit_glyph(input logic [3:0] n);
    logic [7:0] g;
    case (n)
      4'd0:    g = 8'hC0;
      4'd1:    g = 8'hF9;
      4'd2:    g = 8'hA4;
      4'd3:    g = 8'hB0;
      4'd4:    g = 8'h99;
      4'd5:    g = 8'h92;
      4'd6:    g = 8'h82;
      4'd7:    g = 8'hF8;
      4'd8:    g = 8'h80;
      4'd9:    g = 8'h90;
      default: g = G_E;
    endcase
    return g;
  endfunction

  // Load path: only i_load writes the display content; the scan is untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= 16'h0000;
      mode_q <= MODE_BLANK;
    end else if (i_load) begin
      data_q <= i_data_bcd;
      mode_q <= mode_e'(i_disp_state);
    end
  end

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Leading-zero suppression walks down from thousands; only true 0 nibbles count.
  always_comb begin
    nib      = 4'h0;
    lz_blank = 1'b0;
    case (idx_q)
      2'd0: begin
        nib      = data_q[3:0];
        lz_blank = 1'b0;
      end
      2'd1: begin
        nib      = data_q[7:4];
        lz_blank = (data_q[15:4] == 12'h000);
      end
      2'd2: begin
        nib      = data_q[11:8];
        lz_blank = (data_q[15:8] == 8'h00);
      end
      default: begin
        nib      = data_q[15:12];
        lz_blank = (data_q[15:12] == 4'h0);
      end
    endcase
  end

  always_comb begin
    seg_d = G_BLANK;
    case (mode_q)
      MODE_NUM:  seg_d = lz_blank ? G_BLANK : digit_glyph(nib);
      MODE_FAIL: begin
        case (idx_q)
          2'd3:    seg_d = G_F;
          2'd2:    seg_d = G_A;
          2'd1:    seg_d = G_I;
          default: seg_d = G_L;
        endcase
      end
      MODE_DASH: seg_d = G_DASH;
      default:   seg_d = G_BLANK;
    endcase
  end

  // With BLANK_CYC = 0 the window never opens and anodes are driven continuously.
  always_comb begin
    blank_win = (BLANK_CYC != 0) && (cnt_q < BLANK_L);
    an_d      = blank_win ? 4'hF : ~(4'b0001 << idx_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= G_BLANK;
      an_q  <= 4'hF;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign o_seg = seg_q;
  assign o_an  = an_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=8, BLANK_CYC=2.
module tb_seg_scan_driver;

  localparam int SD = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] i_data_bcd = 16'h0;
  logic [1:0]  i_disp_state = 2'b00;
  logic        i_load = 1'b0;
  logic [7:0]  o_seg;
  logic [3:0]  o_an;

  int total = 0;
  int bad = 0;
  int e = 0;  // rising edges since reset release

  seg_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_data_bcd   (i_data_bcd),
    .i_disp_state (i_disp_state),
    .i_load       (i_load),
    .o_seg        (o_seg),
    .o_an         (o_an)
  );

  always #5 clk = ~clk;

  // Outputs after edge e come from the pre-edge counter value e-1.
  function automatic int exp_idx(input int ed);
    return ((ed - 1) / SD) % 4;
  endfunction

  function automatic logic [3:0] exp_an(input int ed);
    logic [3:0] one;
    if (((ed - 1) % SD) < BC) return 4'hF;
    one = 4'b0001 << exp_idx(ed);
    return ~one;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [1:0] m);
    i_data_bcd   = d;
    i_disp_state = m;
    i_load       = 1'b1;
    step();
    i_load = 1'b0;
    step();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    e = 0;
  endtask

  task automatic test_reset();
    release_reset();
    do_load(16'h0008, 2'b00);
    while (e < 5) step();
    total++;
    if (o_an !== 4'hE) begin
      bad++;
      $display("FAIL pre_reset_an got=%h want=%h", o_an, 4'hE);
    end
    total++;
    if (o_seg !== 8'h80) begin
      bad++;
      $display("FAIL pre_reset_seg got=%h want=%h", o_seg, 8'h80);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (o_an !== 4'hF) begin
      bad++;
      $display("FAIL async_reset_an got=%h want=%h", o_an, 4'hF);
    end
    total++;
    if (o_seg !== 8'hFF) begin
      bad++;
      $display("FAIL async_reset_seg got=%h want=%h", o_seg, 8'hFF);
    end
    repeat (3) @(posedge clk);
    release_reset();
    for (int i = 0; i < 40; i++) begin
      step();
      total++;
      if (o_an !== exp_an(e)) begin
        bad++;
        $display("FAIL reset_scan_an edge=%0d got=%h want=%h", e, o_an, exp_an(e));
      end
      total++;
      if (o_seg !== 8'hFF) begin
        bad++;
        $display("FAIL reset_scan_seg edge=%0d got=%h want=%h", e, o_seg, 8'hFF);
      end
    end
  endtask

  task automatic test_number();
    logic [7:0] g[4];
    do_load(16'h0345, 2'b00);
    g[0] = 8'h92; g[1] = 8'h99; g[2] = 8'hB0; g[3] = 8'hFF;
    for (int i = 0; i < 32; i++) begin
      step();
      total++;
      if (o_an !== exp_an(e)) begin
        bad++;
        $display("FAIL num345_an edge=%0d got=%h want=%h", e, o_an, exp_an(e));
      end
      total++;
      if (o_seg !== g[exp_idx(e)]) begin
        bad++;
        $display("FAIL num345_seg digit=%0d got=%h want=%h", exp_idx(e), o_seg, g[exp_idx(e)]);
      end
    end
  endtask

  task automatic test_all_zero();
    logic [7:0] g[4];
    do_load(16'h0000, 2'b00);
    g[0] = 8'hC0; g[1] = 8'hFF; g[2] = 8'hFF; g[3] = 8'hFF;
    for (int i = 0; i < 32; i++) begin
      step();
      total++;
      if (o_seg !== g[exp_idx(e)]) begin
        bad++;
        $display("FAIL zero_seg digit=%0d got=%h want=%h", exp_idx(e), o_seg, g[exp_idx(e)]);
      end
    end
  endtask

  task automatic test_non_bcd();
    logic [7:0] g[4];
    do_load(16'h10A0, 2'b00);
    g[0] = 8'hC0; g[1] = 8'h86; g[2] = 8'hC0; g[3] = 8'hF9;
    for (int i = 0; i < 32; i++) begin
      step();
      total++;
      if (o_seg !== g[exp_idx(e)]) begin
        bad++;
        $display("FAIL nonbcd_seg digit=%0d got=%h want=%h", exp_idx(e), o_seg, g[exp_idx(e)]);
      end
    end
  endtask

  task automatic test_patterns();
    logic [7:0] g[4];
    do_load(16'h1234, 2'b01);
    g[0] = 8'hC7; g[1] = 8'hCF; g[2] = 8'h88; g[3] = 8'h8E;
    for (int i = 0; i < 32; i++) begin
      step();
      total++;
      if (o_seg !== g[exp_idx(e)]) begin
        bad++;
        $display("FAIL fail_seg digit=%0d got=%h want=%h", exp_idx(e), o_seg, g[exp_idx(e)]);
      end
    end
    do_load(16'h1234, 2'b10);
    for (int i = 0; i < 32; i++) begin
      step();
      total++;
      if (o_seg !== 8'hBF) begin
        bad++;
        $display("FAIL dash_seg digit=%0d got=%h want=%h", exp_idx(e), o_seg, 8'hBF);
      end
      total++;
      if (o_an !== exp_an(e)) begin
        bad++;
        $display("FAIL dash_an edge=%0d got=%h want=%h", e, o_an, exp_an(e));
      end
    end
  endtask

  task automatic test_load_latency();
    logic [7:0] g[4];
    int guard;
    int last_start;
    g[0] = 8'h90; g[1] = 8'hFF; g[2] = 8'hFF; g[3] = 8'hFF;
    // Move to a units slot with counter at 4 (display is dashes from before).
    guard = 0;
    while (!((e % SD) == 4 && (e / SD) % 4 == 0) && guard < 64) begin
      step();
      guard++;
    end
    total++;
    if (guard >= 64) begin
      bad++;
      $display("FAIL latency_align got=timeout want=aligned");
    end
    i_data_bcd   = 16'h0009;
    i_disp_state = 2'b00;
    i_load       = 1'b1;
    step();
    i_load = 1'b0;
    total++;
    if (o_seg !== 8'hBF) begin
      bad++;
      $display("FAIL latency_capture_edge got=%h want=%h", o_seg, 8'hBF);
    end
    step();
    total++;
    if (o_seg !== 8'h90) begin
      bad++;
      $display("FAIL latency_next_edge got=%h want=%h", o_seg, 8'h90);
    end
    // Slot period: anode-off windows must start exactly SD edges apart.
    last_start = -1;
    for (int i = 0; i < 32; i++) begin
      logic [3:0] prev_an;
      prev_an = o_an;
      step();
      total++;
      if (o_an !== exp_an(e)) begin
        bad++;
        $display("FAIL latency_scan_an edge=%0d got=%h want=%h", e, o_an, exp_an(e));
      end
      total++;
      if (o_seg !== g[exp_idx(e)]) begin
        bad++;
        $display("FAIL latency_seg digit=%0d got=%h want=%h", exp_idx(e), o_seg, g[exp_idx(e)]);
      end
      if (prev_an != 4'hF && o_an == 4'hF) begin
        if (last_start >= 0) begin
          total++;
          if (e - last_start != SD) begin
            bad++;
            $display("FAIL slot_period got=%0d want=%0d", e - last_start, SD);
          end
        end
        last_start = e;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] g[4];
    g[0] = 8'h80; g[1] = 8'hF8; g[2] = 8'h82; g[3] = 8'h92;
    i_data_bcd   = 16'h1234;
    i_disp_state = 2'b01;
    i_load       = 1'b1;
    step();
    i_data_bcd   = 16'h5678;
    i_disp_state = 2'b00;
    step();
    i_load = 1'b0;
    i_data_bcd   = 16'h9999;
    i_disp_state = 2'b10;
    step();
    for (int i = 0; i < 32; i++) begin
      step();
      total++;
      if (o_seg !== g[exp_idx(e)]) begin
        bad++;
        $display("FAIL b2b_seg digit=%0d got=%h want=%h", exp_idx(e), o_seg, g[exp_idx(e)]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_number();
    test_all_zero();
    test_non_bcd();
    test_patterns();
    test_load_latency();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
